// File: rtl/tdd_sync_gen.sv
// Master-side TDD sync pulse generator: emits bursts or a continuous train of
// periodic pulses with programmable width and period on sync_out.
module tdd_sync_gen #(
    parameter int CNT_W   = 32,
    parameter int BURST_W = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    input  logic               start,
    input  logic               stop,
    input  logic [CNT_W-1:0]   period,
    input  logic [CNT_W-1:0]   width,
    input  logic [BURST_W-1:0] burst_count,
    output logic               sync_out,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [BURST_W-1:0] pulse_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   phase;
    logic [CNT_W-1:0]   period_q;
    logic [CNT_W-1:0]   width_q;
    logic [BURST_W-1:0] burst_q;
    logic               halt;
    logic               cfg_bad;
    logic               last_pulse;

    assign halt       = stop | ~enable;
    assign cfg_bad    = (period < CNT_W'(2)) || (width == '0) || (width >= period);
    assign last_pulse = (burst_q != '0) && (pulse_cnt == burst_q);

    // phase counts down the remaining cycles of the current HIGH or LOW phase;
    // a halt always wins so a pulse may be truncated and done is suppressed
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            phase     <= '0;
            period_q  <= '0;
            width_q   <= '0;
            burst_q   <= '0;
            sync_out  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !halt) begin
                        if (cfg_bad) begin
                            cfg_err <= 1'b1;
                        end else begin
                            state     <= HIGH;
                            period_q  <= period;
                            width_q   <= width;
                            burst_q   <= burst_count;
                            phase     <= width;
                            pulse_cnt <= BURST_W'(1);
                            sync_out  <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (halt) begin
                        state    <= IDLE;
                        sync_out <= 1'b0;
                        busy     <= 1'b0;
                    end else if (phase == CNT_W'(1)) begin
                        sync_out <= 1'b0;
                        if (last_pulse) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= LOW;
                            phase <= period_q - width_q;
                        end
                    end else begin
                        phase <= phase - CNT_W'(1);
                    end
                end
                LOW: begin
                    if (halt) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (phase == CNT_W'(1)) begin
                        state     <= HIGH;
                        sync_out  <= 1'b1;
                        phase     <= width_q;
                        pulse_cnt <= pulse_cnt + BURST_W'(1);
                    end else begin
                        phase <= phase - CNT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    sync_out <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdd_sync_gen.sv
// Self-checking bench for tdd_sync_gen: vector table, hand-written corner
// sequences and randomized traffic against an arithmetic waveform model.
module tb_tdd_sync_gen;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] period = '0;
    logic [31:0] width = '0;
    logic [15:0] burst_count = '0;

    logic        sync_out, busy, done, cfg_err;
    logic [15:0] pulse_cnt;
    logic        sync4, busy4, done4, cfg4;
    logic [3:0]  pc4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tdd_sync_gen dut (
        .clk(clk), .rstn(rstn), .enable(enable), .start(start), .stop(stop),
        .period(period), .width(width), .burst_count(burst_count),
        .sync_out(sync_out), .busy(busy), .done(done), .cfg_err(cfg_err),
        .pulse_cnt(pulse_cnt)
    );

    tdd_sync_gen #(.BURST_W(4)) dut4 (
        .clk(clk), .rstn(rstn), .enable(enable), .start(start), .stop(stop),
        .period(period), .width(width), .burst_count(burst_count[3:0]),
        .sync_out(sync4), .busy(busy4), .done(done4), .cfg_err(cfg4),
        .pulse_cnt(pc4)
    );

    typedef struct {
        logic        st, sp, en;
        int unsigned p, w, b;
        logic        e_sync, e_busy, e_done, e_cfg;
        int unsigned e_pc;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic st, logic sp, logic en, int unsigned p, int unsigned w,
                                int unsigned b, logic es, logic eb, logic ed, logic ec,
                                int unsigned epc);
        vec_t v;
        v.st = st; v.sp = sp; v.en = en; v.p = p; v.w = w; v.b = b;
        v.e_sync = es; v.e_busy = eb; v.e_done = ed; v.e_cfg = ec; v.e_pc = epc;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic st, input logic sp, input logic en,
                                  input int unsigned p, input int unsigned w, input int unsigned b);
        start = st;
        stop = sp;
        enable = en;
        period = p;
        width = w;
        burst_count = 16'(b);
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        apply_stimulus(0, 0, 1, 0, 0, 0);
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // Reference model: an accepted start at cycle m_s fixes the whole waveform
    int          t, m_s, m_p, m_w, m_b;
    bit          m_run, m_cfg;
    int unsigned m_pc;
    logic        e_sync, e_busy, e_done, e_cfg;
    int unsigned e_pc;

    function automatic bit cfg_is_bad(int unsigned p, int unsigned w);
        return (p < 2) || (w == 0) || (w >= p);
    endfunction

    task automatic model_eval();
        int r, endr;
        e_cfg = m_cfg;
        e_sync = 0; e_busy = 0; e_done = 0; e_pc = m_pc;
        if (m_run) begin
            r = t - m_s - 1;
            endr = (m_b - 1) * m_p + m_w;
            if (m_b != 0 && r >= endr) begin
                e_done = (r == endr);
                e_pc = m_b;
            end else begin
                e_busy = 1;
                e_sync = ((r % m_p) < m_w);
                e_pc = ((r / m_p) + 1) & 16'hFFFF;
            end
        end
    endtask

    task automatic rand_cycle(input logic st, input logic sp, input logic en,
                              input int unsigned p, input int unsigned w, input int unsigned b);
        m_cfg = 0;
        if (e_busy) begin
            if (sp || !en) begin
                m_run = 0;
                m_pc = e_pc;
            end
        end else if (st && en && !sp) begin
            if (cfg_is_bad(p, w)) m_cfg = 1;
            else begin
                m_run = 1; m_s = t; m_p = p; m_w = w; m_b = b;
            end
        end
        apply_stimulus(st, sp, en, p, w, b);
        tick();
        t++;
        model_eval();
        check_output("rnd_sync", sync_out, e_sync);
        check_output("rnd_busy", busy, e_busy);
        check_output("rnd_done", done, e_done);
        check_output("rnd_cfg_err", cfg_err, e_cfg);
        check_output("rnd_pulse_cnt", pulse_cnt, e_pc);
        check_output("rnd4_sync", sync4, e_sync);
        check_output("rnd4_busy", busy4, e_busy);
        check_output("rnd4_done", done4, e_done);
        check_output("rnd4_cfg_err", cfg4, e_cfg);
        check_output("rnd4_pulse_cnt", pc4, e_pc & 4'hF);
    endtask

    initial begin
        $display("[TB] tdd_sync_gen bench starting");
        do_reset();
        rstn = 1'b0;
        tick();
        check_output("reset_sync", sync_out, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
        check_output("reset_cfg_err", cfg_err, 0);
        check_output("reset_pulse_cnt", pulse_cnt, 0);
        rstn = 1'b1;

        // Rejections, collision, enable gating, min config train and stop
        vecs[0]  = mk(1, 0, 1, 10, 10, 0, 0, 0, 0, 1, 0);
        vecs[1]  = mk(0, 0, 1, 10, 10, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 1,  1,  1, 0, 0, 0, 0, 1, 0);
        vecs[3]  = mk(0, 0, 1,  1,  1, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 0, 1,  5,  0, 0, 0, 0, 0, 1, 0);
        vecs[5]  = mk(0, 0, 1,  5,  0, 0, 0, 0, 0, 0, 0);
        vecs[6]  = mk(1, 1, 1,  2,  1, 0, 0, 0, 0, 0, 0);
        vecs[7]  = mk(1, 0, 0,  2,  1, 0, 0, 0, 0, 0, 0);
        vecs[8]  = mk(1, 0, 1,  2,  1, 0, 1, 1, 0, 0, 1);
        vecs[9]  = mk(0, 0, 1,  2,  1, 0, 0, 1, 0, 0, 1);
        vecs[10] = mk(0, 0, 1,  2,  1, 0, 1, 1, 0, 0, 2);
        vecs[11] = mk(0, 0, 1,  2,  1, 0, 0, 1, 0, 0, 2);
        vecs[12] = mk(0, 0, 1,  2,  1, 0, 1, 1, 0, 0, 3);
        vecs[13] = mk(0, 1, 1,  2,  1, 0, 0, 0, 0, 0, 3);
        vecs[14] = mk(0, 0, 1,  2,  1, 0, 0, 0, 0, 0, 3);
        vecs[15] = mk(1, 1, 1,  2,  1, 0, 0, 0, 0, 0, 3);
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(vecs[i].st, vecs[i].sp, vecs[i].en, vecs[i].p, vecs[i].w, vecs[i].b);
            tick();
            check_output($sformatf("vec%0d_sync", i), sync_out, vecs[i].e_sync);
            check_output($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            check_output($sformatf("vec%0d_done", i), done, vecs[i].e_done);
            check_output($sformatf("vec%0d_cfg_err", i), cfg_err, vecs[i].e_cfg);
            check_output($sformatf("vec%0d_pulse_cnt", i), pulse_cnt, vecs[i].e_pc);
        end

        // Burst of 3, period 10, width 4
        do_reset();
        apply_stimulus(1, 0, 1, 10, 4, 3);
        tick();
        apply_stimulus(0, 0, 1, 10, 4, 3);
        for (int c = 1; c <= 28; c++) begin
            check_output("b3_sync", sync_out,
                         ((c >= 1 && c <= 4) || (c >= 11 && c <= 14) || (c >= 21 && c <= 24)) ? 1 : 0);
            check_output("b3_busy", busy, (c <= 24) ? 1 : 0);
            check_output("b3_done", done, (c == 25) ? 1 : 0);
            check_output("b3_pulse_cnt", pulse_cnt, (c <= 10) ? 1 : (c <= 20) ? 2 : 3);
            tick();
        end

        // 4-bit pulse counter wraps 15 -> 0 -> 1 without a gap
        do_reset();
        apply_stimulus(1, 0, 1, 3, 1, 0);
        tick();
        apply_stimulus(0, 0, 1, 3, 1, 0);
        for (int c = 1; c <= 51; c++) begin
            check_output("wrap_sync", sync4, (((c - 1) % 3) == 0) ? 1 : 0);
            check_output("wrap_pulse_cnt", pc4, (((c - 1) / 3) + 1) % 16);
            check_output("wrap_done", done4, 0);
            tick();
        end
        apply_stimulus(0, 1, 1, 3, 1, 0);
        tick();
        check_output("wrap_stop_busy", busy4, 0);

        // Back-to-back bursts with a period change mid-burst
        do_reset();
        apply_stimulus(1, 0, 1, 8, 2, 1);
        tick();
        for (int c = 1; c <= 16; c++) begin
            check_output("b2b_sync", sync_out,
                         (c == 1 || c == 2 || c == 4 || c == 5 || c == 12 || c == 13) ? 1 : 0);
            check_output("b2b_done", done, (c == 3 || c == 14) ? 1 : 0);
            check_output("b2b_pulse_cnt", pulse_cnt, (c >= 12) ? 2 : 1);
            if (c == 3) apply_stimulus(1, 0, 1, 8, 2, 2);
            else        apply_stimulus(0, 0, 1, (c >= 5) ? 3 : 8, 2, 2);
            tick();
        end

        // Ignored start while busy, then reset in the middle of a high phase
        do_reset();
        apply_stimulus(1, 0, 1, 6, 3, 0);
        tick();
        for (int c = 1; c <= 8; c++) begin
            check_output("rst_sync", sync_out,
                         ((c >= 1 && c <= 3) || (c >= 7 && c <= 9)) ? 1 : 0);
            check_output("rst_pulse_cnt", pulse_cnt, (c <= 6) ? 1 : 2);
            if (c == 2) apply_stimulus(1, 0, 1, 4, 1, 0);
            else        apply_stimulus(0, 0, 1, 6, 3, 0);
            if (c == 8) rstn = 1'b0;
            tick();
        end
        check_output("rst_mid_sync", sync_out, 0);
        check_output("rst_mid_busy", busy, 0);
        check_output("rst_mid_done", done, 0);
        check_output("rst_mid_cfg_err", cfg_err, 0);
        check_output("rst_mid_pulse_cnt", pulse_cnt, 0);
        rstn = 1'b1;

        // Randomized bursts, aborts and bad configs against the model
        do_reset();
        t = 0; m_s = 0; m_p = 2; m_w = 1; m_b = 0;
        m_run = 0; m_cfg = 0; m_pc = 0;
        model_eval();
        for (int trial = 0; trial < 40; trial++) begin
            int unsigned p, w, b, len;
            p = $urandom_range(2, 10);
            w = $urandom_range(1, p - 1);
            b = $urandom_range(0, 4);
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 2))
                    0:       p = $urandom_range(0, 1);
                    1:       w = 0;
                    default: w = p + $urandom_range(0, 2);
                endcase
            end
            rand_cycle(1, ($urandom_range(0, 7) == 0), 1, p, w, b);
            len = $urandom_range(5, 40);
            for (int k = 0; k < len; k++) begin
                logic st, sp, en;
                st = e_busy && ($urandom_range(0, 5) == 0);
                sp = ($urandom_range(0, 29) == 0);
                en = ($urandom_range(0, 39) != 0);
                rand_cycle(st, sp, en, $urandom_range(0, 12), $urandom_range(0, 12),
                           $urandom_range(0, 6));
            end
            rand_cycle(0, 1, 1, 0, 0, 0);
            rand_cycle(0, 0, 1, 0, 0, 0);
            rand_cycle(0, 0, 1, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tdd_sync_gen.md
# tdd_sync_gen

Master-side TDD sync pulse generator: produces bursts (or a continuous train) of periodic sync pulses with programmable width and period on `sync_out`. The pulses drive the external sync line that remote nodes' sync-input stretchers edge-detect. It sits in the DMA/TDD sync path of the sync master node, under control of a register block or local sequencer.

## Interface
Parameters:
- `CNT_W`, 32, width of `period`/`width` and of the internal phase counter
- `BURST_W`, 16, width of `burst_count` and `pulse_cnt`

Ports:
- `clk` in 1: clock
- `rstn` in 1: reset, synchronous, active-low
- `enable` in 1: level; low forces idle, like `stop`
- `start` in 1: single-cycle request to begin a burst
- `stop` in 1: single-cycle abort request
- `period` in CNT_W: cycles from one rising edge of `sync_out` to the next
- `width` in CNT_W: cycles `sync_out` stays high per pulse
- `burst_count` in BURST_W: pulses per burst; 0 = continuous
- `sync_out` out 1: registered sync pulse output
- `busy` out 1: high while a burst is in progress
- `done` out 1: one-cycle strobe at normal burst completion
- `cfg_err` out 1: one-cycle strobe when a start is rejected for bad config
- `pulse_cnt` out BURST_W: number of pulses emitted in the current or last burst

## Operation
- States: IDLE, HIGH, LOW. All outputs are registered.
- IDLE: `sync_out`=0, `busy`=0.
- A start is accepted when `start`=1, `enable`=1, `stop`=0 and state is IDLE. A start in HIGH or LOW is ignored.
- Config check on start: the start is rejected if `period`<2, `width`=0 or `width`>=`period`.
  - On rejection: `cfg_err`=1 for one cycle, the FSM stays in IDLE, and `pulse_cnt` is unchanged.
- Accepted start:
  - Latches `period`, `width` and `burst_count`; later input changes have no effect until the next start.
  - Next state is HIGH, with `sync_out`=1 and `busy`=1.
  - `pulse_cnt` is loaded to 1 and the phase counter to `width`.
- HIGH: the phase counter decrements each cycle. When the counter reaches 1, the next state is LOW.
  - If a burst is set and `pulse_cnt` equals the latched `burst_count`, the FSM goes to IDLE instead of LOW and `done`=1 that cycle.
- LOW: lasts `period`-`width` cycles. Then the next state is HIGH, and `pulse_cnt` increments in the same cycle `sync_out` rises.
- Continuous mode (`burst_count`=0):
  - Runs until `stop` or `enable`=0.
  - `pulse_cnt` wraps from all-ones to 0 and keeps counting.
  - `done` is never asserted.
- Stop (`stop`=1 or `enable`=0) in HIGH or LOW:
  - Next cycle `sync_out`=0, `busy`=0, state IDLE, no `done`.
  - `pulse_cnt` holds its value.
  - A truncated pulse is allowed.
- Start and stop in the same cycle: stop wins and the start is dropped.
- `pulse_cnt` holds after completion or abort until the next accepted start.

## Timing
- Reset (`rstn`=0 at a clock edge): IDLE, `sync_out`=0, `busy`=0, `done`=0, `cfg_err`=0, `pulse_cnt`=0.
  - Reset mid-burst takes effect at the next edge with no residual pulse.
- Start latency: start sampled at edge N gives `sync_out`=1 from edge N+1.
- Per pulse: `sync_out` is high for exactly `width` cycles. Rising edges are exactly `period` cycles apart.
- The last pulse of a burst has no trailing low phase. `done`=1 and `busy`=0 in the first cycle after the last high cycle.
- Back-to-back bursts: a start sampled in the `done` cycle is accepted. The next `sync_out` rise then follows after exactly 1 low cycle.
- `cfg_err` asserts one cycle after the rejected start.
- Minimum legal config (`period`=2, `width`=1) gives a 50% duty train, toggling every cycle.

## Test plan
- **Burst of 3:** `period`=10, `width`=4, `burst_count`=3, start at cycle 0.
  - `sync_out` high in cycles 1-4, 11-14 and 21-24.
  - `done` in cycle 25, `busy` low from 25.
  - `pulse_cnt`=1, 2, 3 at the rising edges, then holds 3.
- **Config rejection:** start with `width`=10, `period`=10.
  - `cfg_err`=1 in cycle 1, `busy` stays 0, `sync_out` stays 0, `pulse_cnt` unchanged.
  - Repeat with `period`=1, and with `width`=0: same response.
- **Stop and start collision:** continuous mode with `period`=2, `width`=1.
  - `sync_out` toggles 1,0,1,0 from cycle 1.
  - Stop asserted during a high cycle: `sync_out`=0 the next cycle, no `done`.
  - Start and stop asserted together: no burst starts.
- **Counter wrap:** continuous mode with `BURST_W`=4 override and `period`=3.
  - `pulse_cnt` goes ... 15, 0, 1 with no `done` and no gap in the pulse train.
- **Back-to-back and latching:** start asserted in the `done` cycle of a 1-pulse burst (`period`=8, `width`=2).
  - `sync_out` is low for exactly 1 cycle between the two pulses.
  - Change `period` mid-burst: spacing does not change.
- **Reset and ignored start:** `rstn`=0 mid-HIGH.
  - All outputs are 0 at the next edge and `pulse_cnt`=0.
  - `start` while `busy`=1 is ignored: pulse spacing is unchanged.
